lsu_param: RTL and testbench

- Per-thread load/store unit, parametrised in address and data width. One instance per thread per core.
- Executes LDR/STR by driving a valid/ready request to the data-memory controller and returning load data to the register file.
- Adds the following over the fixed 8-bit unit:
  - a base-offset address adder;
  - a read/write conflict check with an error flag;
  - a registered busy indication;
  - an optional watchdog timeout.
- Sits between the core decoder/register file and the memory controller channel for that thread.

---
 rtl/lsu_param.sv | 183 ++++++++++++++++++
 tb/tb_lsu_param.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_param.sv
// Per-thread load/store unit: base+offset addressing, valid/ready memory handshake,
// read/write conflict flag, registered busy. Define LSU_TIMEOUT_EN to add a WAITING watchdog.
module lsu_param #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [ADDR_BITS-1:0] addr_offset,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_busy,
    output logic                 lsu_error
);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        REQUESTING = 2'b01,
        WAITING    = 2'b10,
        DONE       = 2'b11
    } state_t;

    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("lsu_param: TIMEOUT_CYCLES must be >= 1");
    end

    state_t               state_q, state_d;
    logic                 op_write_q, op_write_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;
    logic [ADDR_BITS-1:0] base, ea;

`ifdef LSU_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // A wide base register is truncated to the address width before the add.
    if (DATA_BITS >= ADDR_BITS) begin : g_base_trunc
        assign base = rs[ADDR_BITS-1:0];
    end else begin : g_base_zext
        assign base = {{(ADDR_BITS-DATA_BITS){1'b0}}, rs};
    end

    assign ea = base + addr_offset;

    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        out_d      = out_q;
        error_d    = error_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (core_state == CORE_REQUEST) begin
                    if (decoded_mem_read_enable && decoded_mem_write_enable) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else if (decoded_mem_read_enable || decoded_mem_write_enable) begin
                        op_write_d = decoded_mem_write_enable;
                        error_d    = 1'b0;
                        state_d    = REQUESTING;
                    end
                end
            end
            REQUESTING: begin
                if (op_write_q) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = ea;
                    wr_data_d  = rt;
                end else begin
                    rd_valid_d = 1'b1;
                    rd_addr_d  = ea;
                end
`ifdef LSU_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = WAITING;
            end
            WAITING: begin
                // Only the latched channel's ready matters; ready beats the watchdog.
                if (!op_write_q && mem_read_ready) begin
                    out_d      = mem_read_data;
                    rd_valid_d = 1'b0;
                    state_d    = DONE;
                end else if (op_write_q && mem_write_ready) begin
                    wr_valid_d = 1'b0;
                    state_d    = DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rd_valid_d = 1'b0;
                    wr_valid_d = 1'b0;
                    error_d    = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                if (core_state == CORE_UPDATE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == REQUESTING) || (state_d == WAITING);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            out_q      <= '0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else if (enable) begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign mem_read_valid    = rd_valid_q;
    assign mem_read_address  = rd_addr_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_write_address = wr_addr_q;
    assign mem_write_data    = wr_data_q;
    assign lsu_state         = state_q;
    assign lsu_out           = out_q;
    assign lsu_busy          = busy_q;
    assign lsu_error         = error_q;

endmodule

// File: tb/tb_lsu_param.sv
// Directed bench for lsu_param: 8/8 instance (watchdog 4 when LSU_TIMEOUT_EN) and a 12/16 instance,
// with a request/load-data scoreboard.
module tb_lsu_param;

    logic clk;
    logic reset, enable;

    // 8-bit address / 8-bit data instance
    logic [2:0] a_core;
    logic       a_rd, a_wr, a_rrdy, a_wrdy;
    logic [7:0] a_off, a_rs, a_rt, a_rdata;
    logic       a_rvalid, a_wvalid, a_busy, a_err;
    logic [7:0] a_raddr, a_waddr, a_wdata, a_out;
    logic [1:0] a_state;

    // 12-bit address / 16-bit data instance
    logic [2:0]  b_core;
    logic        b_rd, b_wr, b_rrdy, b_wrdy;
    logic [11:0] b_off;
    logic [15:0] b_rs, b_rt, b_rdata;
    logic        b_rvalid, b_wvalid, b_busy, b_err;
    logic [11:0] b_raddr, b_waddr;
    logic [15:0] b_wdata, b_out;
    logic [1:0]  b_state;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    req_t        req_q[$];
    logic [31:0] ld_q[$];
    int errors = 0;
    int checks = 0;

    lsu_param #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(4)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .core_state(a_core),
        .decoded_mem_read_enable(a_rd), .decoded_mem_write_enable(a_wr),
        .addr_offset(a_off), .rs(a_rs), .rt(a_rt),
        .mem_read_valid(a_rvalid), .mem_read_address(a_raddr),
        .mem_read_ready(a_rrdy), .mem_read_data(a_rdata),
        .mem_write_valid(a_wvalid), .mem_write_address(a_waddr),
        .mem_write_data(a_wdata), .mem_write_ready(a_wrdy),
        .lsu_state(a_state), .lsu_out(a_out), .lsu_busy(a_busy), .lsu_error(a_err)
    );

    lsu_param #(.ADDR_BITS(12), .DATA_BITS(16), .TIMEOUT_CYCLES(4)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .core_state(b_core),
        .decoded_mem_read_enable(b_rd), .decoded_mem_write_enable(b_wr),
        .addr_offset(b_off), .rs(b_rs), .rt(b_rt),
        .mem_read_valid(b_rvalid), .mem_read_address(b_raddr),
        .mem_read_ready(b_rrdy), .mem_read_data(b_rdata),
        .mem_write_valid(b_wvalid), .mem_write_address(b_waddr),
        .mem_write_data(b_wdata), .mem_write_ready(b_wrdy),
        .lsu_state(b_state), .lsu_out(b_out), .lsu_busy(b_busy), .lsu_error(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the next expected request and compare it with what the DUT is presenting.
    task automatic chk_req(input string tag, input logic rv, input logic wv,
                           input logic [31:0] raddr, input logic [31:0] waddr,
                           input logic [31:0] wdata);
        req_t r;
        chk({tag, "_pending"}, 32'(req_q.size() != 0), 32'd1);
        if (req_q.size() != 0) begin
            r = req_q.pop_front();
            chk({tag, "_rvalid"}, 32'(rv), 32'(!r.wr));
            chk({tag, "_wvalid"}, 32'(wv), 32'(r.wr));
            if (r.wr) begin
                chk({tag, "_waddr"}, waddr, r.addr);
                chk({tag, "_wdata"}, wdata, r.data);
            end else begin
                chk({tag, "_raddr"}, raddr, r.addr);
            end
        end
    endtask

    task automatic chk_ld(input string tag, input logic [31:0] obs);
        chk({tag, "_pending"}, 32'(ld_q.size() != 0), 32'd1);
        if (ld_q.size() != 0) chk(tag, obs, ld_q.pop_front());
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1;
        a_core = '0; a_rd = 0; a_wr = 0; a_off = '0; a_rs = '0; a_rt = '0;
        a_rrdy = 0; a_wrdy = 0; a_rdata = '0;
        b_core = '0; b_rd = 0; b_wr = 0; b_off = '0; b_rs = '0; b_rt = '0;
        b_rrdy = 0; b_wrdy = 0; b_rdata = '0;
        tick(); tick();
        chk("rst_state", 32'(a_state), 0);
        chk("rst_rvalid", 32'(a_rvalid), 0);
        chk("rst_wvalid", 32'(a_wvalid), 0);
        chk("rst_out", 32'(a_out), 0);
        chk("rst_busy_err", 32'({a_busy, a_err}), 0);
        chk("rst_b_state", 32'(b_state), 0);

        // Load 0x10+0x05, ready two cycles after valid; stray write ready ignored.
        reset = 1'b0;
        a_core = 3'b011; a_rd = 1; a_rs = 8'h10; a_off = 8'h05;
        req_q.push_back('{1'b0, 32'h15, 32'h0});
        ld_q.push_back(32'hA5);
        tick();
        chk("ld_s1", 32'(a_state), 1);
        chk("ld_busy1", 32'(a_busy), 1);
        chk("ld_rv1", 32'(a_rvalid), 0);
        a_core = 3'b000; a_rd = 0; a_wrdy = 1;
        tick();
        chk("ld_s2", 32'(a_state), 2);
        chk_req("ld_req", a_rvalid, a_wvalid, 32'(a_raddr), 32'(a_waddr), 32'(a_wdata));
        a_rs = 8'h77;
        tick();
        chk("ld_s3", 32'(a_state), 2);
        chk("ld_addr_hold", 32'(a_raddr), 32'h15);
        tick();
        chk("ld_s4", 32'(a_state), 2);
        chk("ld_busy4", 32'(a_busy), 1);
        a_rrdy = 1; a_rdata = 8'hA5; a_wrdy = 0;
        tick();
        chk("ld_s5", 32'(a_state), 3);
        chk("ld_rv5", 32'(a_rvalid), 0);
        chk("ld_busy5", 32'(a_busy), 0);
        chk_ld("ld_data", 32'(a_out));
        a_rrdy = 0; a_rdata = 8'h00;
        tick();
        chk("ld_done_hold", 32'(a_state), 3);
        chk("ld_out_hold", 32'(a_out), 32'hA5);
        a_core = 3'b110;
        tick();
        chk("ld_idle", 32'(a_state), 0);
        a_core = 3'b000;

        // Store with wrapping address, ready already high.
        a_rs = 8'hFE; a_off = 8'h03; a_rt = 8'h3C; a_wr = 1; a_core = 3'b011; a_wrdy = 1;
        req_q.push_back('{1'b1, 32'h01, 32'h3C});
        tick();
        chk("st_s1", 32'(a_state), 1);
        chk("st_wv1", 32'(a_wvalid), 0);
        a_wr = 0; a_core = 3'b000;
        tick();
        chk("st_s2", 32'(a_state), 2);
        chk_req("st_req", a_rvalid, a_wvalid, 32'(a_raddr), 32'(a_waddr), 32'(a_wdata));
        tick();
        chk("st_s3", 32'(a_state), 3);
        chk("st_valids3", 32'({a_rvalid, a_wvalid}), 0);
        chk("st_out_kept", 32'(a_out), 32'hA5);
        a_wrdy = 0; a_core = 3'b110;
        tick();
        chk("st_idle", 32'(a_state), 0);

        // Conflict, then a legal request clears the error.
        a_rd = 1; a_wr = 1; a_core = 3'b011;
        tick();
        chk("cf_state", 32'(a_state), 3);
        chk("cf_err", 32'(a_err), 1);
        chk("cf_valids", 32'({a_rvalid, a_wvalid}), 0);
        chk("cf_busy", 32'(a_busy), 0);
        a_rd = 0; a_wr = 0; a_core = 3'b110;
        tick();
        chk("cf_idle", 32'(a_state), 0);
        chk("cf_sticky", 32'(a_err), 1);
        a_core = 3'b011; a_rd = 1; a_rs = 8'h20; a_off = 8'h00;
        req_q.push_back('{1'b0, 32'h20, 32'h0});
        tick();
        chk("cf_clear_s", 32'(a_state), 1);
        chk("cf_clear_err", 32'(a_err), 0);
        a_core = 3'b000; a_rd = 0;
        tick();
        chk_req("fz_req", a_rvalid, a_wvalid, 32'(a_raddr), 32'(a_waddr), 32'(a_wdata));

        // Freeze in WAITING with ready offered, then reset while disabled.
        enable = 0; a_rrdy = 1; a_rdata = 8'h5A; a_core = 3'b110;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fz_state", 32'(a_state), 2);
            chk("fz_rvalid", 32'(a_rvalid), 1);
            chk("fz_out", 32'(a_out), 32'hA5);
        end
        reset = 1;
        tick();
        chk("mr_state", 32'(a_state), 0);
        chk("mr_rvalid", 32'(a_rvalid), 0);
        chk("mr_raddr", 32'(a_raddr), 0);
        chk("mr_out", 32'(a_out), 0);
        chk("mr_busy_err", 32'({a_busy, a_err}), 0);
        reset = 0; enable = 1; a_rrdy = 0; a_rdata = 8'h00; a_core = 3'b000;

`ifdef LSU_TIMEOUT_EN
        // No ready: abort after four WAITING cycles.
        a_core = 3'b011; a_rd = 1; a_rs = 8'h30; a_off = 8'h01;
        req_q.push_back('{1'b0, 32'h31, 32'h0});
        tick();
        a_core = 3'b000; a_rd = 0;
        tick();
        chk_req("to_req", a_rvalid, a_wvalid, 32'(a_raddr), 32'(a_waddr), 32'(a_wdata));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_wait", 32'(a_state), 2);
        end
        tick();
        chk("to_state", 32'(a_state), 3);
        chk("to_rvalid", 32'(a_rvalid), 0);
        chk("to_err", 32'(a_err), 1);
        chk("to_out", 32'(a_out), 0);
        a_core = 3'b110;
        tick();
        // Ready on the fourth WAITING cycle beats the watchdog.
        a_core = 3'b011; a_rd = 1;
        req_q.push_back('{1'b0, 32'h31, 32'h0});
        ld_q.push_back(32'h66);
        tick();
        chk("tr_err_clr", 32'(a_err), 0);
        a_core = 3'b000; a_rd = 0;
        tick();
        chk_req("tr_req", a_rvalid, a_wvalid, 32'(a_raddr), 32'(a_waddr), 32'(a_wdata));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("tr_wait", 32'(a_state), 2);
        end
        a_rrdy = 1; a_rdata = 8'h66;
        tick();
        chk("tr_state", 32'(a_state), 3);
        chk("tr_err", 32'(a_err), 0);
        chk_ld("tr_data", 32'(a_out));
`else
        // Without the watchdog a silent memory is waited on indefinitely.
        a_core = 3'b011; a_rd = 1; a_rs = 8'h30; a_off = 8'h01;
        req_q.push_back('{1'b0, 32'h31, 32'h0});
        ld_q.push_back(32'h66);
        tick();
        a_core = 3'b000; a_rd = 0;
        tick();
        chk_req("nw_req", a_rvalid, a_wvalid, 32'(a_raddr), 32'(a_waddr), 32'(a_wdata));
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("nw_wait", 32'({a_state, a_rvalid, a_err}), 32'b1010);
        end
        a_rrdy = 1; a_rdata = 8'h66;
        tick();
        chk("nw_state", 32'(a_state), 3);
        chk_ld("nw_data", 32'(a_out));
`endif
        a_rrdy = 0; a_core = 3'b110;
        tick();
        chk("a_final_idle", 32'(a_state), 0);

        // Wide instance: address wrap to 0x000 and a 16-bit load.
        b_core = 3'b011; b_rd = 1; b_rs = 16'h0FFF; b_off = 12'h001;
        b_rrdy = 1; b_rdata = 16'hBEEF;
        req_q.push_back('{1'b0, 32'h000, 32'h0});
        ld_q.push_back(32'hBEEF);
        tick();
        chk("w_s1", 32'(b_state), 1);
        b_core = 3'b000; b_rd = 0;
        tick();
        chk_req("w_ld_req", b_rvalid, b_wvalid, 32'(b_raddr), 32'(b_waddr), 32'(b_wdata));
        tick();
        chk("w_s3", 32'(b_state), 3);
        chk_ld("w_ld_data", 32'(b_out));
        b_rrdy = 0; b_core = 3'b110;
        tick();
        // Wide base is truncated to 12 bits: 0xBCD + 0x010.
        b_core = 3'b011; b_wr = 1; b_rs = 16'hABCD; b_off = 12'h010; b_rt = 16'h1234; b_wrdy = 1;
        req_q.push_back('{1'b1, 32'hBDD, 32'h1234});
        tick();
        b_core = 3'b000; b_wr = 0;
        tick();
        chk_req("w_st_req", b_rvalid, b_wvalid, 32'(b_raddr), 32'(b_waddr), 32'(b_wdata));
        tick();
        chk("w_st_done", 32'({b_state, b_wvalid}), 32'b110);
        b_wrdy = 0;

        chk("sb_drained", 32'(req_q.size() + ld_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
